// File: rtl/stream_frame_writer.sv
// Pixel-stream sink: buffers WREN pixels in a show-ahead FIFO and writes them to a linear frame buffer.
// Optional double buffering is enabled by defining FRAME_DOUBLE_BUF_EN (adds the DISP_BUF output).
module stream_frame_writer #(
  parameter int                WIDTH        = 640,
  parameter int                HEIGHT       = 480,
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(24'h000000),
  parameter int                FIFO_DEPTH   = 16,
  parameter int                PIPE_SLACK   = 4,
  parameter logic [ADDR_W-1:0] FRAME_OFFSET = ADDR_W'(24'h080000)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WREN,
  input  logic [7:0]        IN_R,
  input  logic [7:0]        IN_G,
  input  logic [7:0]        IN_B,
  output logic              STALL,
  output logic              WR_VALID,
  input  logic              WR_READY,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_DATA,
  output logic [11:0]       POSX,
  output logic [11:0]       POSY,
  output logic              FRAME_DONE,
  output logic              OVERFLOW
`ifdef FRAME_DOUBLE_BUF_EN
  ,
  output logic              DISP_BUF
`endif
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   STALL_C = CW'(FIFO_DEPTH - PIPE_SLACK);
  localparam logic [11:0]     X_LAST  = 12'(WIDTH - 1);
  localparam logic [11:0]     Y_LAST  = 12'(HEIGHT - 1);

  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [11:0]       posx_q, posx_d;
  logic [11:0]       posy_q, posy_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              sel_q;
  logic              push, pop, full, wrap;

  always_comb begin
    full = (count_q == DEPTH_C);
    pop  = (count_q != '0) && WR_READY;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push = WREN && (!full || pop);
    wrap = pop && (posx_q == X_LAST) && (posy_q == Y_LAST);
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (WREN & ~push);
  end

  always_comb begin
    posx_d    = posx_q;
    posy_d    = posy_q;
    pix_cnt_d = pix_cnt_q;
    done_d    = wrap;
    if (pop) begin
      if (posx_q == X_LAST) begin
        posx_d = '0;
        posy_d = (posy_q == Y_LAST) ? '0 : posy_q + 12'd1;
      end else begin
        posx_d = posx_q + 12'd1;
      end
      pix_cnt_d = wrap ? '0 : pix_cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {IN_R, IN_G, IN_B};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      posx_q    <= '0;
      posy_q    <= '0;
      pix_cnt_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      posx_q    <= posx_d;
      posy_q    <= posy_d;
      pix_cnt_q <= pix_cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef FRAME_DOUBLE_BUF_EN
  logic disp_q;

  // disp_q captures the buffer just finished, i.e. the select bit before it toggles
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q  <= 1'b0;
      disp_q <= 1'b0;
    end else if (wrap) begin
      sel_q  <= ~sel_q;
      disp_q <= sel_q;
    end
  end

  assign DISP_BUF = disp_q;
`else
  assign sel_q = 1'b0;
`endif

  always_comb begin
    WR_VALID   = (count_q != '0);
    WR_DATA    = WR_VALID ? {8'h00, mem_q[rd_ptr_q]} : '0;
    STALL      = (count_q >= STALL_C);
    WR_ADDR    = (sel_q ? (BASE_ADDR + FRAME_OFFSET) : BASE_ADDR) + pix_cnt_q;
    POSX       = posx_q;
    POSY       = posy_q;
    FRAME_DONE = done_q;
    OVERFLOW   = ovf_q;
  end

endmodule

// File: tb/tb_stream_frame_writer.sv
// Bench for stream_frame_writer: directed vector table, hand sequences and random traffic vs a queue model.
module tb_stream_frame_writer;

  localparam int          W    = 4;
  localparam int          H    = 2;
  localparam int          FD   = 16;
  localparam int          PS   = 4;
  localparam logic [23:0] BASE = 24'h000100;
  localparam logic [23:0] OFF  = 24'h080000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WREN = 1'b0;
  logic [7:0]  IN_R = '0, IN_G = '0, IN_B = '0;
  logic        WR_READY = 1'b0;
  logic        STALL, WR_VALID, FRAME_DONE, OVERFLOW;
  logic [23:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [11:0] POSX, POSY;
`ifdef FRAME_DOUBLE_BUF_EN
  logic        DISP_BUF;
`endif

  stream_frame_writer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(24), .BASE_ADDR(BASE),
    .FIFO_DEPTH(FD), .PIPE_SLACK(PS), .FRAME_OFFSET(OFF)
  ) dut (
    .CLK(CLK), .RST(RST), .WREN(WREN), .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B),
    .STALL(STALL), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .POSX(POSX), .POSY(POSY), .FRAME_DONE(FRAME_DONE),
    .OVERFLOW(OVERFLOW)
`ifdef FRAME_DOUBLE_BUF_EN
    , .DISP_BUF(DISP_BUF)
`endif
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  logic [23:0] mq[$];
  int          m_acc, m_frames;
  bit          m_done, m_ovf;

  // accept log sampled from the DUT at handshake time, plus FRAME_DONE bookkeeping
  logic [11:0] lx[$], ly[$];
  logic [23:0] laddr[$];
  logic [31:0] ldata[$];
  int          done_cnt;
  logic        disp_log[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void model_update(bit rst, bit wren, logic [23:0] rgb, bit ready);
    bit pop, push;
    if (rst) begin
      mq.delete(); m_acc = 0; m_frames = 0; m_done = 0; m_ovf = 0;
      return;
    end
    pop  = (mq.size() != 0) && ready;
    push = wren && ((mq.size() < FD) || pop);
    m_done = 0;
    if (pop) begin
      void'(mq.pop_front());
      if ((m_acc % (W*H)) == W*H-1) begin m_done = 1; m_frames++; end
      m_acc++;
    end
    if (push) mq.push_back(rgb);
    if (wren && !push) m_ovf = 1;
  endfunction

  function automatic logic [23:0] exp_addr(int acc);
    logic [23:0] a;
    a = BASE + 24'(acc % (W*H));
`ifdef FRAME_DOUBLE_BUF_EN
    if (((acc / (W*H)) % 2) == 1) a = a + OFF;
`endif
    return a;
  endfunction

  task automatic check_model(string tag);
    int pos;
    pos = m_acc % (W*H);
    chk({tag, "_valid"}, 32'(WR_VALID), 32'(mq.size() != 0));
    chk({tag, "_data"},  WR_DATA, (mq.size() != 0) ? {8'h00, mq[0]} : 32'h0);
    chk({tag, "_addr"},  32'(WR_ADDR), 32'(exp_addr(m_acc)));
    chk({tag, "_posx"},  32'(POSX), 32'(pos % W));
    chk({tag, "_posy"},  32'(POSY), 32'(pos / W));
    chk({tag, "_stall"}, 32'(STALL), 32'(mq.size() >= FD-PS));
    chk({tag, "_done"},  32'(FRAME_DONE), 32'(m_done));
    chk({tag, "_ovf"},   32'(OVERFLOW), 32'(m_ovf));
`ifdef FRAME_DOUBLE_BUF_EN
    chk({tag, "_disp"},  32'(DISP_BUF), (m_frames == 0) ? 32'h0 : 32'((m_frames-1) % 2));
`endif
  endtask

  task automatic step(input bit rst, input bit wren, input logic [23:0] rgb, input bit ready);
    RST = rst; WREN = wren; {IN_R, IN_G, IN_B} = rgb; WR_READY = ready;
    if (WR_VALID && ready && !rst) begin
      lx.push_back(POSX); ly.push_back(POSY); laddr.push_back(WR_ADDR); ldata.push_back(WR_DATA);
    end
    @(posedge CLK);
    model_update(rst, wren, rgb, ready);
    #1;
    if (FRAME_DONE === 1'b1) begin
      done_cnt++;
`ifdef FRAME_DOUBLE_BUF_EN
      disp_log.push_back(DISP_BUF);
`endif
    end
  endtask

  task automatic clear_log();
    lx.delete(); ly.delete(); laddr.delete(); ldata.delete(); disp_log.delete(); done_cnt = 0;
  endtask

  typedef struct {
    bit          rst, wren, ready;
    logic [23:0] rgb;
    logic        e_valid;
    logic [31:0] e_data;
    logic [23:0] e_addr;
    logic [11:0] e_x, e_y;
    logic        e_stall, e_done, e_ovf;
  } vec_t;

  vec_t vt[9];
  logic [11:0] fx[10], fy[10];

  initial begin
    vt[0] = '{1, 0, 0, 24'h0,      0, 32'h0,        24'h100, 0, 0, 0, 0, 0};
    vt[1] = '{0, 1, 1, 24'h123456, 1, 32'h00123456, 24'h100, 0, 0, 0, 0, 0};
    vt[2] = '{0, 0, 1, 24'h0,      0, 32'h0,        24'h101, 1, 0, 0, 0, 0};
    vt[3] = '{0, 1, 0, 24'hABCDEF, 1, 32'h00ABCDEF, 24'h101, 1, 0, 0, 0, 0};
    vt[4] = '{0, 1, 0, 24'h010203, 1, 32'h00ABCDEF, 24'h101, 1, 0, 0, 0, 0};
    vt[5] = '{0, 0, 1, 24'h0,      1, 32'h00010203, 24'h102, 2, 0, 0, 0, 0};
    vt[6] = '{0, 0, 1, 24'h0,      0, 32'h0,        24'h103, 3, 0, 0, 0, 0};
    vt[7] = '{0, 1, 1, 24'h777777, 1, 32'h00777777, 24'h103, 3, 0, 0, 0, 0};
    vt[8] = '{0, 0, 1, 24'h0,      0, 32'h0,        24'h104, 0, 1, 0, 0, 0};
    fx = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    fy = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    // directed vector table (single pixel, backpressure hold, row wrap)
    for (int i = 0; i < 9; i++) begin
      step(vt[i].rst, vt[i].wren, vt[i].rgb, vt[i].ready);
      chk($sformatf("vec%0d_valid", i), 32'(WR_VALID), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_data", i),  WR_DATA, vt[i].e_data);
      chk($sformatf("vec%0d_addr", i),  32'(WR_ADDR), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d_posx", i),  32'(POSX), 32'(vt[i].e_x));
      chk($sformatf("vec%0d_posy", i),  32'(POSY), 32'(vt[i].e_y));
      chk($sformatf("vec%0d_stall", i), 32'(STALL), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d_done", i),  32'(FRAME_DONE), 32'(vt[i].e_done));
      chk($sformatf("vec%0d_ovf", i),   32'(OVERFLOW), 32'(vt[i].e_ovf));
    end

    // backpressure: 17 pushes into a stalled port, then drain
    step(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 24'h100000 + 24'(i), 0);
      check_model($sformatf("bp%0d", i));
      if (i == 10) chk("bp_stall_after11", 32'(STALL), 32'h0);
      if (i == 11) chk("bp_stall_after12", 32'(STALL), 32'h1);
    end
    chk("bp_overflow", 32'(OVERFLOW), 32'h1);
    clear_log();
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 1);
      check_model("bp_drain");
    end
    chk("bp_writes", 32'(ldata.size()), 32'd16);
    for (int k = 0; k < 16 && k < ldata.size(); k++) begin
      chk($sformatf("bp_data%0d", k), ldata[k], {8'h00, 24'h100000 + 24'(k)});
      chk($sformatf("bp_addr%0d", k), 32'(laddr[k]), 32'(exp_addr(k)));
    end
    chk("bp_overflow_sticky", 32'(OVERFLOW), 32'h1);

    // frame wrap: 10 pixels through a 4x2 frame
    step(1, 0, 0, 0);
    clear_log();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 24'h200000 + 24'(i), 1);
      check_model("fw");
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check_model("fw_drain");
    end
    chk("fw_writes", 32'(lx.size()), 32'd10);
    for (int k = 0; k < 10 && k < lx.size(); k++) begin
      chk($sformatf("fw_x%0d", k), 32'(lx[k]), 32'(fx[k]));
      chk($sformatf("fw_y%0d", k), 32'(ly[k]), 32'(fy[k]));
    end
    chk("fw_done_pulses", 32'(done_cnt), 32'd1);
`ifdef FRAME_DOUBLE_BUF_EN
    if (laddr.size() > 8) chk("fw_addr9", 32'(laddr[8]), 32'(BASE + OFF));
`else
    if (laddr.size() > 8) chk("fw_addr9", 32'(laddr[8]), 32'(BASE));
`endif

    // full FIFO with simultaneous push and pop
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 24'h300000 + 24'(i), 0);
      check_model("full_fill");
    end
    clear_log();
    step(0, 1, 24'h3000FF, 1);
    check_model("full_pushpop");
    chk("full_pp_ovf", 32'(OVERFLOW), 32'h0);
    chk("full_pp_stall", 32'(STALL), 32'h1);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 1);
      check_model("full_drain");
    end
    chk("full_writes", 32'(ldata.size()), 32'd17);
    if (ldata.size() == 17) chk("full_last_data", ldata[16], 32'h003000FF);

    // reset mid-frame discards buffered pixels and position
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 24'h400000 + 24'(i), 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 24'h410000 + 24'(i), 0);
    step(1, 0, 0, 0);
    chk("rst_valid", 32'(WR_VALID), 32'h0);
    chk("rst_stall", 32'(STALL), 32'h0);
    chk("rst_data", WR_DATA, 32'h0);
    clear_log();
    step(0, 1, 24'h0ABC01, 1);
    step(0, 0, 0, 1);
    chk("rst_writes", 32'(lx.size()), 32'd1);
    if (lx.size() == 1) begin
      chk("rst_posx", 32'(lx[0]), 32'h0);
      chk("rst_posy", 32'(ly[0]), 32'h0);
      chk("rst_addr", 32'(laddr[0]), 32'(BASE));
      chk("rst_data1", ldata[0], 32'h000ABC01);
    end

`ifdef FRAME_DOUBLE_BUF_EN
    // double buffering: two full frames land in alternate buffers
    step(1, 0, 0, 0);
    clear_log();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 24'h500000 + 24'(i), 1);
      check_model("db");
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("db_writes", 32'(laddr.size()), 32'd16);
    for (int k = 0; k < 16 && k < laddr.size(); k++)
      chk($sformatf("db_addr%0d", k), 32'(laddr[k]),
          32'((k < 8) ? BASE + 24'(k) : BASE + OFF + 24'(k - 8)));
    chk("db_done_pulses", 32'(disp_log.size()), 32'd2);
    if (disp_log.size() == 2) begin
      chk("db_disp_first", 32'(disp_log[0]), 32'h0);
      chk("db_disp_second", 32'(disp_log[1]), 32'h1);
    end
`endif

    // randomized traffic with varying backpressure against the queue model
    step(1, 0, 0, 0);
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      for (int i = 0; i < 120; i++) begin
        bit r, w, rd;
        r  = ($urandom_range(0, 299) == 0);
        w  = ($urandom_range(0, 99) < 75);
        rd = ($urandom_range(0, 99) < rdy_pct);
        step(r, w, 24'($urandom), rd);
        check_model("rnd");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stream_frame_writer.md
Name: stream_frame_writer

Overview:
- Sink end of the filter stream interface: consumes the WREN + OUT_R/G/B pixel stream that any filter stage emits and writes the pixels into a linear frame buffer through a valid/ready memory-write port.
- Buffers pixels in a small FIFO and raises STALL early so the upstream source can drop its READY before the FIFO overflows.
- Tracks the write position (X/Y) and pulses FRAME_DONE when the last pixel of a frame is accepted by memory.

Parameters:
- WIDTH, 640, pixels per line; must be >=2.
- HEIGHT, 480, lines per frame; must be >=1.
- ADDR_W, 24, width of the word address.
- BASE_ADDR, 24'h000000, word address of pixel (0,0).
- FIFO_DEPTH, 16, pixel FIFO entries; must be a power of 2.
- PIPE_SLACK, 4, free entries still remaining when STALL asserts; covers filter latency in flight.
- FRAME_OFFSET, 24'h080000, address distance to the second buffer; used only with FRAME_DOUBLE_BUF_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- WREN  in  1  pixel valid from the filter; one pixel per cycle while high
- IN_R  in  8  red, sampled when WREN=1
- IN_G  in  8  green, sampled when WREN=1
- IN_B  in  8  blue, sampled when WREN=1
- STALL  out  1  almost-full; upstream ANDs its READY with ~STALL
- WR_VALID  out  1  memory write request valid
- WR_READY  in  1  memory accepts the request
- WR_ADDR  out  ADDR_W  word address of the head pixel
- WR_DATA  out  32  {8'h00, R, G, B}
- POSX  out  12  column of the head pixel
- POSY  out  12  row of the head pixel
- FRAME_DONE  out  1  one-cycle pulse on acceptance of pixel (WIDTH-1, HEIGHT-1)
- OVERFLOW  out  1  sticky; set when a pixel is dropped

Behaviour:
- Reset (RST=1 at a CLK edge)
  - FIFO emptied; count=0.
  - Pixel counter, POSX and POSY set to 0.
  - WR_VALID=0, STALL=0, FRAME_DONE=0, OVERFLOW=0, WR_DATA=0.
  - WR_ADDR=BASE_ADDR.
  - Reset mid-frame discards all buffered pixels; the next WREN pixel is written as (0,0).
- FIFO
  - Show-ahead FIFO with registered count.
  - Push: WREN=1 and (count<FIFO_DEPTH or pop in the same cycle).
  - Pop: WR_VALID && WR_READY.
- Latency
  - A pixel pushed at edge n is presented on WR_VALID/WR_DATA after edge n (one-cycle latency) when the FIFO was empty.
  - Throughput is one pixel per cycle while WR_READY=1.
- Memory handshake
  - WR_VALID = (count != 0).
  - WR_ADDR, WR_DATA, POSX and POSY are stable while WR_VALID=1 and WR_READY=0.
  - WR_VALID never drops without an accept, except on reset.
- Position and address (advance only on pop)
  - POSX increments; at WIDTH-1 it wraps to 0 and POSY increments.
  - At (WIDTH-1, HEIGHT-1), POSX and POSY both wrap to 0.
  - WR_ADDR = buffer base + linear pixel counter; the counter returns to 0 at frame wrap. No multiplier.
- FRAME_DONE is registered: high exactly the cycle after the pop of the last pixel of a frame.
- STALL = (count >= FIFO_DEPTH-PIPE_SLACK), decoded from the count register.
- Boundary cases
  - Full with no pop, WREN=1: pixel dropped; count, data and counters unchanged; OVERFLOW set until reset.
  - Full with a pop in the same cycle, WREN=1: push accepted; count unchanged.
  - Empty with WREN=1 and WR_READY=1: no bypass; the pixel is presented the next cycle.
  - WREN gaps of any length are allowed; no timeout.

Optional Feature:
- Macro: FRAME_DOUBLE_BUF_EN.
- Defined:
  - A buffer-select bit toggles on every frame wrap, in the same edge as the wrap.
  - Buffer base = BASE_ADDR when the bit is 0, BASE_ADDR+FRAME_OFFSET when it is 1.
  - Reset clears the bit.
  - Extra output DISP_BUF (1 bit) = index of the last completed buffer, i.e. the inverse of the select bit after the first FRAME_DONE; DISP_BUF=0 from reset.
- Undefined: single buffer at BASE_ADDR; DISP_BUF port absent.

Test Plan:
- Single pixel: WREN one cycle with R=8'h12, G=8'h34, B=8'h56, WR_READY=1 -> WR_VALID high exactly one cycle, the cycle after WREN; WR_DATA=32'h00123456, WR_ADDR=BASE_ADDR, POSX=0, POSY=0.
- Backpressure (FIFO_DEPTH=16, PIPE_SLACK=4, WR_READY=0): 17 consecutive WREN pixels -> STALL rises the cycle after the 12th push; 17th pixel dropped; OVERFLOW=1. Then WR_READY=1 -> exactly 16 writes, at addresses BASE..BASE+15, with data in input order.
- Frame wrap (WIDTH=4, HEIGHT=2): 10 pixels -> POSX/POSY sequence (0,0)..(3,0),(0,1)..(3,1),(0,0),(1,0); FRAME_DONE one pulse after the 8th accept; 9th pixel at WR_ADDR=BASE_ADDR.
- Full with simultaneous push/pop: fill to 16, then WREN=1 and WR_READY=1 together -> count stays 16, no drop, OVERFLOW stays 0.
- Reset mid-frame: 5 pixels buffered with WR_READY=0, RST one cycle -> WR_VALID=0, STALL=0; next pixel written at POSX=0, POSY=0, WR_ADDR=BASE_ADDR.
- With FRAME_DOUBLE_BUF_EN (WIDTH=4, HEIGHT=2): 16 pixels -> first frame at BASE..BASE+7, second at BASE+FRAME_OFFSET..+7; DISP_BUF=0 after the first FRAME_DONE and 1 after the second.
